// File: rtl/ashley_led_decoder.sv
// Receive-side decoder for the ashley LED ring: filters the five LED lines and
// tracks ring position, rotation direction, revolutions and sequence errors.
module ashley_led_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             led_d1_top,
    input  logic             led_d2_right,
    input  logic             led_d3_bottom,
    input  logic             led_d4_left,
    input  logic             led_d5_middle,
    output logic [1:0]       pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             locked,
    output logic             mid,
    output logic             step,
    output logic             rev,
    output logic             err,
    output logic [CNT_W-1:0] rev_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int SCW = $clog2(STABLE_CYCLES + 2);
    // Counter parks one above the accept value so each stable code is accepted once.
    localparam logic [SCW-1:0] ACCEPT_CNT = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] SAT_CNT    = SCW'(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    function automatic logic ring_onehot(input logic [3:0] ring);
        return (ring != 4'd0) && ((ring & (ring - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] ring_index(input logic [3:0] ring);
        logic [1:0] idx;
        case (ring)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [4:0]       raw_s;
    logic [4:0]       sync1_q, sync2_q, prev_q;
    logic [SCW-1:0]   stab_q, stab_d;
    logic             accept_s;
    logic             ring_pos_s, ring_blank_s;
    logic [1:0]       ring_idx_s;
    logic [1:0]       pos_inc_s, pos_dec_s, pos_exp_s;

    state_t           state_q, state_d;
    logic [1:0]       pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             mid_q, mid_d;
    logic             step_q, step_d;
    logic             rev_q, rev_d;
    logic             err_q, err_d;
    logic [1:0]       step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] rev_count_q, rev_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign raw_s = {led_d5_middle, led_d4_left, led_d3_bottom, led_d2_right, led_d1_top};

    // Synchroniser, previous-code register and stability counter.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 5'd0;
            sync2_q <= 5'd0;
            prev_q  <= 5'd0;
            stab_q  <= '0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
        end
    end

    // Stability counter next value and acceptance strobe.
    always_comb begin
        stab_d = stab_q;
        if (sync2_q != prev_q) begin
            stab_d = '0;
        end else if (stab_q != SAT_CNT) begin
            stab_d = stab_q + {{(SCW-1){1'b0}}, 1'b1};
        end else begin
            stab_d = stab_q;
        end
        accept_s     = (sync2_q == prev_q) && (stab_q == ACCEPT_CNT);
        ring_pos_s   = ring_onehot(sync2_q[3:0]);
        ring_blank_s = (sync2_q[3:0] == 4'd0);
        ring_idx_s   = ring_index(sync2_q[3:0]);
        pos_inc_s    = pos_q + 2'd1;
        pos_dec_s    = pos_q - 2'd1;
        pos_exp_s    = dir_q ? pos_dec_s : pos_inc_s;
    end

    // Sequence FSM next-state and output decode.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        dir_d       = dir_q;
        mid_d       = mid_q;
        step_d      = 1'b0;
        rev_d       = 1'b0;
        err_d       = 1'b0;
        step_cnt_d  = step_cnt_q;
        rev_count_d = rev_count_q;

        if (accept_s) begin
            mid_d = sync2_q[4];
            if (!ring_pos_s && !ring_blank_s) begin
                err_d       = 1'b1;
                state_d     = ST_IDLE;
                pos_valid_d = 1'b0;
                step_cnt_d  = 2'd0;
            end else if (ring_blank_s) begin
                state_d = state_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d     = ST_LOCKING;
                        pos_d       = ring_idx_s;
                        pos_valid_d = 1'b1;
                    end
                    ST_LOCKING: begin
                        if (ring_idx_s == pos_q) begin
                            state_d = ST_LOCKING;
                        end else if (ring_idx_s == pos_inc_s || ring_idx_s == pos_dec_s) begin
                            dir_d      = (ring_idx_s == pos_dec_s);
                            state_d    = ST_TRACK;
                            pos_d      = ring_idx_s;
                            step_d     = 1'b1;
                            step_cnt_d = 2'd1;
                        end else begin
                            err_d = 1'b1;
                            pos_d = ring_idx_s;
                        end
                    end
                    ST_TRACK: begin
                        if (ring_idx_s == pos_exp_s) begin
                            step_d = 1'b1;
                            pos_d  = ring_idx_s;
                            if (step_cnt_q == 2'd3) begin
                                rev_d       = 1'b1;
                                step_cnt_d  = 2'd0;
                                rev_count_d = rev_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                step_cnt_d = step_cnt_q + 2'd1;
                            end
                        end else if (ring_idx_s == pos_q) begin
                            state_d = ST_TRACK;
                        end else begin
                            err_d      = 1'b1;
                            state_d    = ST_LOCKING;
                            pos_d      = ring_idx_s;
                            step_cnt_d = 2'd0;
                        end
                    end
                    default: begin
                        state_d     = ST_IDLE;
                        pos_valid_d = 1'b0;
                        step_cnt_d  = 2'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end

        if (err_d && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_count_d = err_count_q;
        end
        locked_d = (state_d == ST_TRACK);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            pos_q       <= 2'd0;
            pos_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            locked_q    <= 1'b0;
            mid_q       <= 1'b0;
            step_q      <= 1'b0;
            rev_q       <= 1'b0;
            err_q       <= 1'b0;
            step_cnt_q  <= 2'd0;
            rev_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
            locked_q    <= locked_d;
            mid_q       <= mid_d;
            step_q      <= step_d;
            rev_q       <= rev_d;
            err_q       <= err_d;
            step_cnt_q  <= step_cnt_d;
            rev_count_q <= rev_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign dir       = dir_q;
    assign locked    = locked_q;
    assign mid       = mid_q;
    assign step      = step_q;
    assign rev       = rev_q;
    assign err       = err_q;
    assign rev_count = rev_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ashley_led_decoder.sv
// Directed self-checking bench for ashley_led_decoder; a second instance with
// CNT_W=2 shares the stimulus to exercise error-counter saturation.
module tb_ashley_led_decoder;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic top = 1'b0, right = 1'b0, bottom = 1'b0, left = 1'b0, middle = 1'b0;

    logic [1:0] pos;
    logic       pos_valid, dir, locked, mid, step, rev, err;
    logic [7:0] rev_count, err_count;

    logic [1:0] s_pos;
    logic       s_pos_valid, s_dir, s_locked, s_mid, s_step, s_rev, s_err;
    logic [1:0] s_rev_count, s_err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int step_tot = 0, rev_tot = 0, err_tot = 0, s_err_tot = 0, overlap_tot = 0;
    int b_step, b_rev, b_err, b_serr;

    localparam logic [4:0] C_BLANK = 5'b00000;
    localparam logic [4:0] C_P0    = 5'b00001;
    localparam logic [4:0] C_P1    = 5'b00010;
    localparam logic [4:0] C_P2    = 5'b00100;
    localparam logic [4:0] C_P3    = 5'b01000;
    localparam logic [4:0] C_ILL   = 5'b00011;

    always #5 clk = ~clk;

    ashley_led_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .nRst(nRst),
        .led_d1_top(top), .led_d2_right(right), .led_d3_bottom(bottom),
        .led_d4_left(left), .led_d5_middle(middle),
        .pos(pos), .pos_valid(pos_valid), .dir(dir), .locked(locked), .mid(mid),
        .step(step), .rev(rev), .err(err),
        .rev_count(rev_count), .err_count(err_count)
    );

    ashley_led_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .nRst(nRst),
        .led_d1_top(top), .led_d2_right(right), .led_d3_bottom(bottom),
        .led_d4_left(left), .led_d5_middle(middle),
        .pos(s_pos), .pos_valid(s_pos_valid), .dir(s_dir), .locked(s_locked), .mid(s_mid),
        .step(s_step), .rev(s_rev), .err(s_err),
        .rev_count(s_rev_count), .err_count(s_err_count)
    );

    // Pulse tallies, sampled between active edges.
    always @(negedge clk) begin
        if (step) step_tot++;
        if (rev) rev_tot++;
        if (err) err_tot++;
        if (s_err) s_err_tot++;
        if ((err && (step || rev)) || (rev && !step)) overlap_tot++;
    end

    task automatic set_leds(input logic [4:0] c);
        {middle, left, bottom, right, top} = c;
    endtask

    task automatic hold(input logic [4:0] c, input int n);
        set_leds(c);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_step = step_tot; b_rev = rev_tot; b_err = err_tot; b_serr = s_err_tot;
    endtask

    task automatic reset_dut();
        nRst = 1'b0;
        set_leds(C_BLANK);
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        set_leds(C_BLANK);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        snap();
        repeat (20) @(negedge clk);
        n_checks++; if ({pos, pos_valid, dir, locked, mid} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {pos, pos_valid, dir, locked, mid}); end
        n_checks++; if ({step, rev, err} !== 3'd0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {step, rev, err}); end
        n_checks++; if ({rev_count, err_count} !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %h expected 0000", {rev_count, err_count}); end
        n_checks++; if ((step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err) !== 0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", (step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err)); end
    endtask

    task automatic test_clockwise();
        reset_dut();
        snap();
        set_leds(C_P0);
        repeat (7) @(negedge clk);
        n_checks++; if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge6: pos_valid got %b expected 0", pos_valid); end
        @(negedge clk);
        n_checks++; if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL latency_edge7: pos_valid got %b expected 1", pos_valid); end
        repeat (2) @(negedge clk);
        hold(C_P1, 10);
        n_checks++; if ({locked, dir, pos} !== 4'b1001) begin n_fail++; $display("FAIL cw_lock: locked/dir/pos got %b expected 1001", {locked, dir, pos}); end
        hold(C_P2, 10);
        hold(C_P3, 10);
        n_checks++; if (rev_tot - b_rev !== 0) begin n_fail++; $display("FAIL cw_no_early_rev: got %0d expected 0", rev_tot - b_rev); end
        hold(C_P0, 10);
        n_checks++; if (step_tot - b_step !== 4) begin n_fail++; $display("FAIL cw_steps: got %0d expected 4", step_tot - b_step); end
        n_checks++; if (rev_tot - b_rev !== 1) begin n_fail++; $display("FAIL cw_rev_pulses: got %0d expected 1", rev_tot - b_rev); end
        n_checks++; if (rev_count !== 8'd1) begin n_fail++; $display("FAIL cw_rev_count: got %0d expected 1", rev_count); end
        n_checks++; if ({pos, err_count} !== {2'd0, 8'd0}) begin n_fail++; $display("FAIL cw_pos_err: got pos %0d err_count %0d expected 0 0", pos, err_count); end
    endtask

    task automatic test_counter_clockwise();
        reset_dut();
        snap();
        hold(C_P3, 10);
        hold(C_P2, 10);
        hold(C_P1, 10);
        hold(C_P0, 10);
        hold(C_P3, 10);
        n_checks++; if ({locked, dir} !== 2'b11) begin n_fail++; $display("FAIL ccw_dir: locked/dir got %b expected 11", {locked, dir}); end
        n_checks++; if (rev_count !== 8'd1) begin n_fail++; $display("FAIL ccw_rev_count: got %0d expected 1", rev_count); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL ccw_err_count: got %0d expected 0", err_count); end
        n_checks++; if (step_tot - b_step !== 4) begin n_fail++; $display("FAIL ccw_steps: got %0d expected 4", step_tot - b_step); end
    endtask

    task automatic test_glitch();
        reset_dut();
        hold(C_P0, 10);
        snap();
        hold(C_ILL, 2);
        hold(C_P0, 10);
        n_checks++; if ((step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err) !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", (step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err)); end
        n_checks++; if ({pos, pos_valid, locked} !== 4'b0010) begin n_fail++; $display("FAIL glitch_state: pos/valid/locked got %b expected 0010", {pos, pos_valid, locked}); end
    endtask

    task automatic test_track_error();
        reset_dut();
        hold(C_P0, 10);
        hold(C_P1, 10);
        snap();
        hold(C_P3, 10);
        n_checks++; if (err_tot - b_err !== 1) begin n_fail++; $display("FAIL trk_err_pulse: got %0d expected 1", err_tot - b_err); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL trk_err_count: got %0d expected 1", err_count); end
        n_checks++; if ({locked, pos, pos_valid} !== 4'b0111) begin n_fail++; $display("FAIL trk_relock_state: locked/pos/valid got %b expected 0111", {locked, pos, pos_valid}); end
        hold(C_P0, 10);
        n_checks++; if ({locked, dir, pos} !== 4'b1000) begin n_fail++; $display("FAIL trk_relock: locked/dir/pos got %b expected 1000", {locked, dir, pos}); end
    endtask

    task automatic test_illegal();
        reset_dut();
        hold(C_P0, 10);
        hold(C_P1, 10);
        snap();
        hold(C_ILL, 10);
        n_checks++; if (err_tot - b_err !== 1) begin n_fail++; $display("FAIL ill_err_pulse: got %0d expected 1", err_tot - b_err); end
        n_checks++; if ({pos_valid, locked, pos} !== 4'b0001) begin n_fail++; $display("FAIL ill_state: valid/locked/pos got %b expected 0001", {pos_valid, locked, pos}); end
        snap();
        hold(C_P2, 10);
        n_checks++; if (step_tot - b_step !== 0) begin n_fail++; $display("FAIL ill_idle_no_step: got %0d expected 0", step_tot - b_step); end
        n_checks++; if ({pos_valid, locked, pos} !== 4'b1010) begin n_fail++; $display("FAIL ill_idle_relock: valid/locked/pos got %b expected 1010", {pos_valid, locked, pos}); end
    endtask

    task automatic test_saturation();
        reset_dut();
        snap();
        for (int i = 0; i < 5; i++) begin
            hold(C_ILL, 10);
            hold(C_BLANK, 10);
        end
        n_checks++; if (s_err_count !== 2'd3) begin n_fail++; $display("FAIL sat_err_count: got %0d expected 3", s_err_count); end
        n_checks++; if (s_err_tot - b_serr !== 5) begin n_fail++; $display("FAIL sat_err_pulses: got %0d expected 5", s_err_tot - b_serr); end
        n_checks++; if (err_count !== 8'd5) begin n_fail++; $display("FAIL wide_err_count: got %0d expected 5", err_count); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        hold(C_P0 | 5'b10000, 10);
        hold(C_P1 | 5'b10000, 10);
        hold(C_P2 | 5'b10000, 10);
        n_checks++; if ({mid, locked, pos} !== 4'b1110) begin n_fail++; $display("FAIL ar_pre: mid/locked/pos got %b expected 1110", {mid, locked, pos}); end
        @(posedge clk);
        #2;
        nRst = 1'b0;
        #1;
        n_checks++; if ({pos, pos_valid, dir, locked, mid, step, rev, err} !== 9'd0) begin n_fail++; $display("FAIL ar_clear: got %b expected 000000000", {pos, pos_valid, dir, locked, mid, step, rev, err}); end
        n_checks++; if ({rev_count, err_count} !== 16'd0) begin n_fail++; $display("FAIL ar_counts: got %h expected 0000", {rev_count, err_count}); end
        @(negedge clk);
        nRst = 1'b1;
        snap();
        repeat (12) @(negedge clk);
        n_checks++; if ((step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err) !== 0) begin n_fail++; $display("FAIL ar_release_pulses: got %0d expected 0", (step_tot - b_step) + (rev_tot - b_rev) + (err_tot - b_err)); end
        n_checks++; if ({mid, pos_valid, locked, pos} !== 5'b11010) begin n_fail++; $display("FAIL ar_reacquire: mid/valid/locked/pos got %b expected 11010", {mid, pos_valid, locked, pos}); end
    endtask

    initial begin
        test_reset();
        test_clockwise();
        test_counter_clockwise();
        test_glitch();
        test_track_error();
        test_illegal();
        test_saturation();
        test_async_reset();
        n_checks++; if (overlap_tot !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", overlap_tot); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
